// File: rtl/wb_pkg.sv
// Shared types and helpers for the registered write-back stage.
// Optional feature macro used by wb_stage: WB_FWD_EN (adds bypass outputs).
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_D  = 3'd3,
    LD_BU = 3'd4,
    LD_HU = 3'd5,
    LD_WU = 3'd6
  } ld_type_e;

  // Access size codes: byte, half, word, dword
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Offset bits that must be zero for a naturally aligned access of this size
  function automatic logic [2:0] f_size_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic f_misaligned(input logic [1:0] size, input logic [2:0] ofs);
    return |(ofs & f_size_mask(size));
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load data alignment: picks the addressed byte/half/word/dword
// out of the raw memory word and sign- or zero-extends it to XLEN.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]             i_mem_data,
  input  logic [$clog2(XLEN/8)-1:0]   i_ofs,
  input  logic [2:0]                  i_ld_type,
  output logic [XLEN-1:0]             o_data,
  output logic                        o_misalign
);

  localparam int OW = $clog2(XLEN/8);

  logic [1:0]      w_size;
  logic            w_unsigned;
  logic [2:0]      w_ofs3;
  logic [2:0]      w_mask;
  logic [OW-1:0]   w_aofs;
  logic [XLEN-1:0] w_shifted;

  // Decode load type into access size and extension; dword/WU fall back to LW on RV32
  always_comb begin
    w_size     = SZ_W;
    w_unsigned = 1'b0;
    case (i_ld_type)
      LD_B:    w_size = SZ_B;
      LD_H:    w_size = SZ_H;
      LD_W:    w_size = SZ_W;
      LD_D:    w_size = (XLEN == 64) ? SZ_D : SZ_W;
      LD_BU:   begin w_size = SZ_B; w_unsigned = 1'b1; end
      LD_HU:   begin w_size = SZ_H; w_unsigned = 1'b1; end
      LD_WU:   begin w_size = SZ_W; w_unsigned = (XLEN == 64); end
      default: w_size = SZ_W;
    endcase
  end

  // Lane select: round the offset down to the access size and shift that lane to bit 0
  always_comb begin
    w_ofs3     = 3'(i_ofs);
    w_mask     = f_size_mask(w_size);
    w_aofs     = OW'(w_ofs3 & ~w_mask);
    w_shifted  = i_mem_data >> {w_aofs, 3'b000};
    o_misalign = f_misaligned(w_size, w_ofs3);
  end

  // Extension of the selected lane to full width
  always_comb begin
    o_data = w_shifted;
    case (w_size)
      SZ_B: o_data = w_unsigned ? XLEN'(w_shifted[7:0])  : XLEN'($signed(w_shifted[7:0]));
      SZ_H: o_data = w_unsigned ? XLEN'(w_shifted[15:0]) : XLEN'($signed(w_shifted[15:0]));
      SZ_W: o_data = w_unsigned ? XLEN'(w_shifted[31:0]) : XLEN'($signed(w_shifted[31:0]));
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered write-back stage: result select, load alignment, one-entry output
// register toward the register-file write port, and retired-instruction counter.
// Optional macro WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data bypass outputs.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CNTW = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(NREG)-1:0]  in_rd,
  input  logic                     in_we,
  input  logic [1:0]               in_wb_sel,
  input  logic [2:0]               in_ld_type,
  input  logic [XLEN-1:0]          in_alu_result,
  input  logic [XLEN-1:0]          in_mem_data,
  input  logic [XLEN-1:0]          in_pc4,
  input  logic [XLEN-1:0]          in_imm,
  output logic                     rf_we,
  output logic [$clog2(NREG)-1:0]  rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  input  logic                     rf_wready,
  output logic                     wb_err,
`ifdef WB_FWD_EN
  output logic                     fwd_valid,
  output logic [$clog2(NREG)-1:0]  fwd_rd,
  output logic [XLEN-1:0]          fwd_data,
`endif
  output logic [CNTW-1:0]          instret
);

  localparam int AW = $clog2(NREG);
  localparam int OW = $clog2(XLEN/8);

  logic            r_out_valid;
  logic            r_rf_we;
  logic            r_err;
  logic [AW-1:0]   r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic [CNTW-1:0] r_instret;

  logic            w_accept;
  logic            w_retire;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_mis;
  logic [XLEN-1:0] w_sel_data;
  logic            w_err_next;
  logic            w_we_next;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .i_mem_data (in_mem_data),
    .i_ofs      (in_alu_result[OW-1:0]),
    .i_ld_type  (in_ld_type),
    .o_data     (w_ld_data),
    .o_misalign (w_ld_mis)
  );

  assign in_ready = !r_out_valid | rf_wready;
  assign w_accept = in_valid & in_ready;
  assign w_retire = r_out_valid & rf_wready;

  // Result source select and write-enable qualification ahead of the output register
  always_comb begin
    w_sel_data = in_alu_result;
    case (in_wb_sel)
      WB_ALU:  w_sel_data = in_alu_result;
      WB_MEM:  w_sel_data = w_ld_data;
      WB_PC4:  w_sel_data = in_pc4;
      default: w_sel_data = in_imm;
    endcase
    w_err_next = (in_wb_sel == WB_MEM) & w_ld_mis;
    w_we_next  = in_we & (in_rd != '0) & !w_err_next;
  end

  // Output-register control: load on accept, empty on retire-only, count retirements
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_rf_we     <= 1'b0;
      r_err       <= 1'b0;
      r_instret   <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_rf_we     <= w_we_next;
        r_err       <= w_err_next;
      end else if (w_retire) begin
        r_out_valid <= 1'b0;
        r_rf_we     <= 1'b0;
        r_err       <= 1'b0;
      end
      if (w_retire) r_instret <= r_instret + CNTW'(1);
    end
  end

  // Output-register payload: misaligned loads carry zero data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_waddr <= in_rd;
      r_wdata <= w_err_next ? '0 : w_sel_data;
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign wb_err   = r_err;
  assign instret  = r_instret;

`ifdef WB_FWD_EN
  assign fwd_valid = r_rf_we;
  assign fwd_rd    = r_waddr;
  assign fwd_data  = r_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (XLEN=32): vector table for select/alignment,
// plus hand-written stall, streaming and asynchronous-reset sequences.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_we;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_ld_type;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_data;
  logic [31:0] in_pc4;
  logic [31:0] in_imm;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wready;
  logic        wb_err;
  logic [63:0] instret;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  wb_stage #(.XLEN(32), .NREG(32), .CNTW(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_we         (in_we),
    .in_wb_sel     (in_wb_sel),
    .in_ld_type    (in_ld_type),
    .in_alu_result (in_alu_result),
    .in_mem_data   (in_mem_data),
    .in_pc4        (in_pc4),
    .in_imm        (in_imm),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .rf_wready     (rf_wready),
    .wb_err        (wb_err),
`ifdef WB_FWD_EN
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
`endif
    .instret       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  ld;
    logic [31:0] src;      // ALU/PC4/IMM value, or byte offset for loads
    logic [4:0]  rd;
    logic        we;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;
  longint exp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid      = 1'b1;
    in_wb_sel     = v.sel;
    in_ld_type    = v.ld;
    in_rd         = v.rd;
    in_we         = v.we;
    in_mem_data   = 32'h80FF7F01;
    in_alu_result = (v.sel == 2'd1) ? (32'h10000000 | v.src) :
                    (v.sel == 2'd0) ? v.src : 32'h0BAD0000;
    in_pc4        = (v.sel == 2'd2) ? v.src : 32'hAAAA0004;
    in_imm        = (v.sel == 2'd3) ? v.src : 32'h55550000;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] val);
    vec_t v;
    v = '{sel: 2'd0, ld: 3'd0, src: val, rd: rd, we: 1'b1,
          exp_we: 1'b1, exp_data: val, exp_err: 1'b0};
    drive(v);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rf_we"},    64'(rf_we),    64'd0);
    chk({tag, "_rf_waddr"}, 64'(rf_waddr), 64'd0);
    chk({tag, "_rf_wdata"}, 64'(rf_wdata), 64'd0);
    chk({tag, "_wb_err"},   64'(wb_err),   64'd0);
    chk({tag, "_instret"},  instret,       64'd0);
  endtask

  initial begin
    int writes;
    // memory word 0x80FF7F01: byte0=01 byte1=7F byte2=FF byte3=80
    vecs[0]  = '{2'd1, 3'd0, 32'd2, 5'd5,  1'b1, 1'b1, 32'hFFFFFFFF, 1'b0}; // LB  ofs2
    vecs[1]  = '{2'd1, 3'd4, 32'd3, 5'd6,  1'b1, 1'b1, 32'h00000080, 1'b0}; // LBU ofs3
    vecs[2]  = '{2'd1, 3'd0, 32'd1, 5'd7,  1'b1, 1'b1, 32'h0000007F, 1'b0}; // LB  ofs1
    vecs[3]  = '{2'd1, 3'd0, 32'd3, 5'd8,  1'b1, 1'b1, 32'hFFFFFF80, 1'b0}; // LB  ofs3
    vecs[4]  = '{2'd1, 3'd4, 32'd0, 5'd9,  1'b1, 1'b1, 32'h00000001, 1'b0}; // LBU ofs0
    vecs[5]  = '{2'd1, 3'd1, 32'd0, 5'd10, 1'b1, 1'b1, 32'h00007F01, 1'b0}; // LH  ofs0
    vecs[6]  = '{2'd1, 3'd1, 32'd2, 5'd11, 1'b1, 1'b1, 32'hFFFF80FF, 1'b0}; // LH  ofs2
    vecs[7]  = '{2'd1, 3'd5, 32'd2, 5'd12, 1'b1, 1'b1, 32'h000080FF, 1'b0}; // LHU ofs2
    vecs[8]  = '{2'd1, 3'd1, 32'd1, 5'd13, 1'b1, 1'b0, 32'h00000000, 1'b1}; // LH  ofs1 misaligned
    vecs[9]  = '{2'd1, 3'd2, 32'd0, 5'd14, 1'b1, 1'b1, 32'h80FF7F01, 1'b0}; // LW  ofs0
    vecs[10] = '{2'd1, 3'd2, 32'd2, 5'd15, 1'b1, 1'b0, 32'h00000000, 1'b1}; // LW  ofs2 misaligned
    vecs[11] = '{2'd1, 3'd3, 32'd0, 5'd16, 1'b1, 1'b1, 32'h80FF7F01, 1'b0}; // LD  -> LW
    vecs[12] = '{2'd1, 3'd6, 32'd0, 5'd17, 1'b1, 1'b1, 32'h80FF7F01, 1'b0}; // LWU -> LW
    vecs[13] = '{2'd1, 3'd7, 32'd0, 5'd18, 1'b1, 1'b1, 32'h80FF7F01, 1'b0}; // code 7 -> LW
    vecs[14] = '{2'd1, 3'd3, 32'd1, 5'd19, 1'b1, 1'b0, 32'h00000000, 1'b1}; // LD ofs1 -> LW misaligned
    vecs[15] = '{2'd0, 3'd0, 32'h1234, 5'd0, 1'b1, 1'b0, 32'h00001234, 1'b0}; // ALU to x0
    vecs[16] = '{2'd0, 3'd0, 32'hDEADBEEF, 5'd20, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[17] = '{2'd2, 3'd0, 32'h00001004, 5'd21, 1'b1, 1'b1, 32'h00001004, 1'b0};
    vecs[18] = '{2'd3, 3'd0, 32'hFFFFF000, 5'd31, 1'b1, 1'b1, 32'hFFFFF000, 1'b0};
    vecs[19] = '{2'd0, 3'd0, 32'h0000ABCD, 5'd22, 1'b0, 1'b0, 32'h0000ABCD, 1'b0}; // we=0
    vecs[20] = '{2'd1, 3'd5, 32'd3, 5'd1,  1'b1, 1'b0, 32'h00000000, 1'b1}; // LHU ofs3 misaligned
    vecs[21] = '{2'd1, 3'd0, 32'd0, 5'd0,  1'b1, 1'b0, 32'h00000001, 1'b0}; // LB to x0

    rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_we = 1'b0; in_wb_sel = '0;
    in_ld_type = '0; in_alu_result = '0; in_mem_data = '0; in_pc4 = '0; in_imm = '0;
    rf_wready = 1'b1;
    #1;
    check_all_zero("reset");
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #3 rst_n = 1'b1;
    step();

    // Table: one instruction, observe the held entry, then its retirement
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_rf_we", i),    64'(rf_we),    64'(vecs[i].exp_we));
      chk($sformatf("v%0d_rf_wdata", i), 64'(rf_wdata), 64'(vecs[i].exp_data));
      chk($sformatf("v%0d_wb_err", i),   64'(wb_err),   64'(vecs[i].exp_err));
      chk($sformatf("v%0d_rf_waddr", i), 64'(rf_waddr), 64'(vecs[i].rd));
      step();
      exp_cnt++;
      chk($sformatf("v%0d_instret", i),  instret,       64'(exp_cnt));
      chk($sformatf("v%0d_idle_we", i),  64'(rf_we),    64'd0);
      chk($sformatf("v%0d_idle_err", i), 64'(wb_err),   64'd0);
    end

    // Stall: entry A held while rf_wready low for 3 cycles, B waiting upstream
    drive_alu(5'd1, 32'h00000111);
    step();
    rf_wready = 1'b0;
    drive_alu(5'd2, 32'h00000222);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
      step();
      chk($sformatf("stall%0d_rf_we", c),    64'(rf_we),    64'd1);
      chk($sformatf("stall%0d_rf_wdata", c), 64'(rf_wdata), 64'h111);
      chk($sformatf("stall%0d_rf_waddr", c), 64'(rf_waddr), 64'd1);
      chk($sformatf("stall%0d_instret", c),  instret,       64'(exp_cnt));
    end
    rf_wready = 1'b1;
    #1;
    chk("unstall_in_ready", 64'(in_ready), 64'd1);
    step();
    exp_cnt++;
    in_valid = 1'b0;
    chk("unstall_B_waddr", 64'(rf_waddr), 64'd2);
    chk("unstall_B_wdata", 64'(rf_wdata), 64'h222);
    chk("unstall_B_we",    64'(rf_we),    64'd1);
    chk("unstall_instret", instret,       64'(exp_cnt));
    step();
    exp_cnt++;
    chk("unstall_B_retired", instret,      64'(exp_cnt));
    chk("unstall_idle_we",   64'(rf_we),   64'd0);

    // Back-to-back stream of 100 with the write port always ready
    writes = 0;
    for (int i = 0; i < 100; i++) begin
      drive_alu(5'((i % 31) + 1), 32'(i + 1));
      step();
      if (rf_we === 1'b1) writes++;
      chk($sformatf("b2b%0d_wdata", i), 64'(rf_wdata), 64'(i + 1));
      chk($sformatf("b2b%0d_instret", i), instret, 64'(exp_cnt + longint'(i)));
    end
    in_valid = 1'b0;
    step();
    exp_cnt += 100;
    chk("b2b_writes", 64'(writes), 64'd100);
    chk("b2b_instret", instret, 64'(exp_cnt));

    // Asynchronous reset while an entry is held and stalled
    rf_wready = 1'b0;
    drive_alu(5'd9, 32'hCAFEF00D);
    step();
    in_valid = 1'b0;
    chk("prerst_rf_we", 64'(rf_we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    rf_wready = 1'b1;
    step();
    #3 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("postrst%0d_rf_we", c), 64'(rf_we), 64'd0);
      chk($sformatf("postrst%0d_instret", c), instret, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
